ram_dp_init: RTL and testbench
==============================

Name: ram_dp_init

Overview:
- Parametrised successor to the single-port tristate program/data RAM.
- Separate read and write data buses; no tristate.
- Port A is read/write with byte enables; port B is read-only, e.g. instruction fetch. Both are synchronous, all operations on posedge clk.
- A built-in init sequencer rewrites the whole array after every reset, in one of two modes: zero or identity.
- During init the RAM refuses requests and reports busy.

Parameters:
- DWIDTH, 32, data word width; must be a multiple of 8.
- AWIDTH, 10, address width.
- MEMDEPTH, 1024, number of words; must satisfy MEMDEPTH <= 2**AWIDTH.
- INIT_MODE, 1, init pattern: 0 writes mem[i]=0; 1 writes mem[i]=i, zero-extended or truncated to DWIDTH.
- FWD_EN, 1, enables port-B read-during-write forwarding.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- a_req, input, 1, port A request valid.
- a_we, input, 1, port A write (1) or read (0) when a_req.
- a_be, input, DWIDTH/8, port A byte write enables.
- a_addr, input, AWIDTH, port A word address.
- a_wdata, input, DWIDTH, port A write data.
- a_rdata, output, DWIDTH, port A read data.
- a_rvalid, output, 1, port A read data valid; one-cycle pulse.
- b_req, input, 1, port B read request.
- b_addr, input, AWIDTH, port B word address.
- b_rdata, output, DWIDTH, port B read data.
- b_rvalid, output, 1, port B read data valid; one-cycle pulse.
- ready, output, 1, high when requests are accepted.
- init_busy, output, 1, high while the init sequencer runs.
- addr_err, output, 1, one-cycle pulse on an out-of-range access.

Behaviour:
- Reset (asynchronous, active-high):
  - Immediately forces ready=0, init_busy=1, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, addr_err=0, init counter=0, FSM=INIT.
  - Array contents are not cleared asynchronously.
- FSM states: INIT and RUN.
  - INIT, first rising edge with reset low: write the pattern to mem[cnt], then cnt++.
  - After writing mem[MEMDEPTH-1], go to RUN on the same edge.
  - INIT lasts exactly MEMDEPTH cycles after reset deassertion.
  - In RUN: init_busy=0, ready=1.
  - RUN has no exit except reset. Reset asserted mid-INIT restarts init from cnt=0.
- While ready=0, a_req/b_req are ignored: no writes, no rvalid, no addr_err.
- Port A write (a_req & a_we):
  - Byte k of mem[a_addr] takes a_wdata[8k+7:8k] when a_be[k]; other bytes unchanged.
  - a_be=0 is a legal no-op.
  - No response pulse.
- Port A read (a_req & !a_we):
  - Registered read, latency 1. a_rdata=mem[a_addr] and a_rvalid=1 on the cycle after the request.
  - a_rdata holds its last value when a_rvalid=0.
- Port B read: same timing as a port A read, using b_rdata/b_rvalid.
- Same-cycle port A write and port B read to the same address:
  - FWD_EN=1: b_rdata returns the merged new word, i.e. old bytes for unenabled lanes.
  - FWD_EN=0: b_rdata returns the old word.
- Port A read and port B read to the same address: both return identical data.
- Back-to-back requests are accepted every cycle, giving full throughput on both ports.
- Out-of-range address (addr >= MEMDEPTH):
  - Write is dropped.
  - Read returns 0 with rvalid=1.
  - addr_err pulses 1 on the following cycle; it is the OR of both ports.
- Width rules:
  - The identity pattern uses the low DWIDTH bits of i.
  - No wrap-around of addresses; out-of-range is handled as above, never aliased.

Test Plan:
- Reset then idle, defaults → init_busy=1 for 1024 cycles, then ready=1. Port B reads of addr 0, 5, 1023 return 0x0, 0x5, 0x3FF.
- Write 0xDEADBEEF to addr 7 with a_be=4'b1111, then a_be=4'b0010 with a_wdata=0x0000AA00 → a port A read of addr 7 one cycle later returns 0xDEADAAEF with a_rvalid pulsing once.
- Same cycle: port A writes 0x12345678 to addr 3 with be=4'b0011, port B reads addr 3 (prior value 0x3) → b_rdata=0x00005678 with FWD_EN=1, 0x00000003 with FWD_EN=0.
- Port A write to addr 2000 with MEMDEPTH=1024, AWIDTH=11 → memory unchanged, addr_err pulses 1 cycle later. A read of addr 2000 returns 0 with rvalid=1.
- Assert reset at init cycle 500, release → init restarts; ready rises exactly 1024 cycles after release. A_req/b_req asserted during init produce no rvalid and no writes.
- INIT_MODE=0: write addr 9 ← 0xFFFFFFFF, pulse reset, wait for init → a read of addr 9 returns 0x0.

Source files
------------

// File: rtl/ram_dp_init.sv
// Dual-port synchronous RAM: port A read/write with byte enables, port B read-only.
// After every reset an init sequencer rewrites the whole array (zero or identity) before accepting requests.
module ram_dp_init #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 10,
  parameter int MEMDEPTH  = 1024,
  parameter int INIT_MODE = 1,
  parameter int FWD_EN    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [DWIDTH/8-1:0] a_be,
  input  logic [AWIDTH-1:0]   a_addr,
  input  logic [DWIDTH-1:0]   a_wdata,
  output logic [DWIDTH-1:0]   a_rdata,
  output logic                a_rvalid,
  input  logic                b_req,
  input  logic [AWIDTH-1:0]   b_addr,
  output logic [DWIDTH-1:0]   b_rdata,
  output logic                b_rvalid,
  output logic                ready,
  output logic                init_busy,
  output logic                addr_err
);

  localparam int NB = DWIDTH / 8;
  localparam int IW = (MEMDEPTH > 1) ? $clog2(MEMDEPTH) : 1;
  localparam logic [AWIDTH:0] DEPTH = (AWIDTH + 1)'(MEMDEPTH);
  localparam logic [IW-1:0]   LAST  = IW'(MEMDEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [IW-1:0]     cnt;
  logic [DWIDTH-1:0] mem [MEMDEPTH];

  logic              a_in, b_in, a_wr, a_rd, b_rd, init_we, fwd_hit;
  logic [IW-1:0]     a_idx, b_idx;
  logic [DWIDTH-1:0] a_word, b_word, b_next;

  function automatic logic [DWIDTH-1:0] init_word(input logic [IW-1:0] i);
    logic [DWIDTH-1:0] w;
    w = '0;
    if (INIT_MODE == 1)
      for (int k = 0; k < DWIDTH && k < IW; k++) w[k] = i[k];
    return w;
  endfunction

  function automatic logic [DWIDTH-1:0] merge_bytes(input logic [DWIDTH-1:0] old_w,
                                                    input logic [DWIDTH-1:0] new_w,
                                                    input logic [NB-1:0]     be);
    logic [DWIDTH-1:0] w;
    w = old_w;
    for (int k = 0; k < NB; k++)
      if (be[k]) w[8*k +: 8] = new_w[8*k +: 8];
    return w;
  endfunction

  // Out-of-range addresses are rejected outright, never aliased onto the low index bits.
  assign a_in    = {1'b0, a_addr} < DEPTH;
  assign b_in    = {1'b0, b_addr} < DEPTH;
  assign a_idx   = a_addr[IW-1:0];
  assign b_idx   = b_addr[IW-1:0];
  assign a_word  = mem[a_idx];
  assign b_word  = mem[b_idx];

  assign a_wr    = ready & a_req & a_we & a_in;
  assign a_rd    = ready & a_req & ~a_we;
  assign b_rd    = ready & b_req;
  assign init_we = (state == INIT) & ~reset;
  assign fwd_hit = (FWD_EN != 0) & a_wr & (a_addr == b_addr);
  assign b_next  = fwd_hit ? merge_bytes(b_word, a_wdata, a_be) : b_word;

  // NOTE: clocked blocks use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      cnt       <= '0;
      ready     <= 1'b0;
      init_busy <= 1'b1;
    end else if (state == INIT) begin
      cnt <= cnt + IW'(1);
      if (cnt == LAST) begin
        state     <= RUN;
        ready     <= 1'b1;
        init_busy <= 1'b0;
      end
    end
  end

  // NOTE: the array has no reset; the init sequencer owns its contents after every reset.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[cnt] <= init_word(cnt);
    end else if (a_wr) begin
      for (int k = 0; k < NB; k++)
        if (a_be[k]) mem[a_idx][8*k +: 8] <= a_wdata[8*k +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rdata  <= '0;
      a_rvalid <= 1'b0;
      b_rdata  <= '0;
      b_rvalid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      a_rvalid <= a_rd;
      b_rvalid <= b_rd;
      addr_err <= ready & ((a_req & ~a_in) | (b_req & ~b_in));
      if (a_rd) a_rdata <= a_in ? a_word : '0;
      if (b_rd) b_rdata <= b_in ? b_next : '0;
    end
  end

endmodule

// File: tb/tb_ram_dp_init.sv
// Bench for ram_dp_init: two configurations driven from shared stimulus and checked every cycle
// against an array-level reference model, plus directed literal expectations.
module tb_ram_dp_init;

  logic        clk = 1'b0, reset = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0;
  logic [3:0]  a_be = '0;
  logic [10:0] a_addr = '0, b_addr = '0;
  logic [31:0] a_wdata = '0;

  logic [31:0] a_rdata_v [2];
  logic [31:0] b_rdata_v [2];
  logic        a_rvalid_v [2];
  logic        b_rvalid_v [2];
  logic        ready_v [2];
  logic        busy_v [2];
  logic        err_v [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Instance 0: identity init with forwarding; instance 1: zero init, no forwarding, odd depth.
  int depth [2] = '{1024, 48};
  int mask  [2] = '{2047, 63};
  bit fwd   [2] = '{1'b1, 1'b0};
  bit mode  [2] = '{1'b1, 1'b0};

  ram_dp_init #(.DWIDTH(32), .AWIDTH(11), .MEMDEPTH(1024), .INIT_MODE(1), .FWD_EN(1)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata_v[0]), .a_rvalid(a_rvalid_v[0]),
    .b_req(b_req), .b_addr(b_addr), .b_rdata(b_rdata_v[0]), .b_rvalid(b_rvalid_v[0]),
    .ready(ready_v[0]), .init_busy(busy_v[0]), .addr_err(err_v[0])
  );

  ram_dp_init #(.DWIDTH(32), .AWIDTH(6), .MEMDEPTH(48), .INIT_MODE(0), .FWD_EN(0)) dut0 (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr[5:0]), .a_wdata(a_wdata),
    .a_rdata(a_rdata_v[1]), .a_rvalid(a_rvalid_v[1]),
    .b_req(b_req), .b_addr(b_addr[5:0]), .b_rdata(b_rdata_v[1]), .b_rvalid(b_rvalid_v[1]),
    .ready(ready_v[1]), .init_busy(busy_v[1]), .addr_err(err_v[1])
  );

  always #5 clk = ~clk;

  // Reference model: array contents plus expected registered outputs.
  logic [31:0] m [2][2048];
  logic [31:0] ea_rd [2];
  logic [31:0] eb_rd [2];
  logic        ea_rv [2];
  logic        eb_rv [2];
  logic        e_err [2];
  int          cyc [2];

  function automatic int ad(input int i, input logic [10:0] x);
    return int'(x) & mask[i];
  endfunction

  function automatic bit ok(input int i, input logic [10:0] x);
    return ad(i, x) < depth[i];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    return {be[3] ? n[31:24] : o[31:24], be[2] ? n[23:16] : o[23:16],
            be[1] ? n[15:8]  : o[15:8],  be[0] ? n[7:0]   : o[7:0]};
  endfunction

  // Init rewrites everything before any access is possible, so the model fills the array at reset.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        cyc[i]   <= 0;
        ea_rd[i] <= '0;
        eb_rd[i] <= '0;
        ea_rv[i] <= 1'b0;
        eb_rv[i] <= 1'b0;
        e_err[i] <= 1'b0;
        for (int k = 0; k < 2048; k++) m[i][k] <= mode[i] ? 32'(k) : 32'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (cyc[i] < depth[i]) begin
          cyc[i]   <= cyc[i] + 1;
          ea_rv[i] <= 1'b0;
          eb_rv[i] <= 1'b0;
          e_err[i] <= 1'b0;
        end else begin
          ea_rv[i] <= a_req && !a_we;
          eb_rv[i] <= b_req;
          e_err[i] <= (a_req && !ok(i, a_addr)) || (b_req && !ok(i, b_addr));
          if (a_req && !a_we)
            ea_rd[i] <= ok(i, a_addr) ? m[i][ad(i, a_addr)] : 32'd0;
          if (b_req)
            eb_rd[i] <= !ok(i, b_addr) ? 32'd0 :
                        (fwd[i] && a_req && a_we && ok(i, a_addr) && ad(i, a_addr) == ad(i, b_addr))
                          ? merge(m[i][ad(i, b_addr)], a_wdata, a_be) : m[i][ad(i, b_addr)];
          if (a_req && a_we && ok(i, a_addr))
            m[i][ad(i, a_addr)] <= merge(m[i][ad(i, a_addr)], a_wdata, a_be);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("ready[%0d]", i),    32'(ready_v[i]),    32'(cyc[i] >= depth[i]));
      check($sformatf("busy[%0d]", i),     32'(busy_v[i]),     32'(cyc[i] < depth[i]));
      check($sformatf("a_rvalid[%0d]", i), 32'(a_rvalid_v[i]), 32'(ea_rv[i]));
      check($sformatf("b_rvalid[%0d]", i), 32'(b_rvalid_v[i]), 32'(eb_rv[i]));
      check($sformatf("addr_err[%0d]", i), 32'(err_v[i]),      32'(e_err[i]));
      check($sformatf("a_rdata[%0d]", i),  a_rdata_v[i],       ea_rd[i]);
      check($sformatf("b_rdata[%0d]", i),  b_rdata_v[i],       eb_rd[i]);
    end
  end

  // One request cycle; returns at the negedge where the registered response is visible.
  task automatic drive(input bit ar, input bit aw, input logic [10:0] aa, input logic [31:0] wd,
                       input logic [3:0] be, input bit br, input logic [10:0] ba);
    @(negedge clk);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = wd; a_be = be;
    b_req = br; b_addr = ba;
    @(negedge clk);
    a_req = 1'b0; a_we = 1'b0; b_req = 1'b0;
  endtask

  task automatic wait_ready;
    for (int k = 0; k < 1200 && ready_v[0] !== 1'b1; k++) @(negedge clk);
    check("init_done", 32'(ready_v[0]), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    // Requests during init must be ignored: no write, no rvalid, no addr_err.
    repeat (9) @(negedge clk);
    drive(1, 1, 11'd20, 32'hCAFEF00D, 4'hF, 1, 11'd20);
    drive(1, 0, 11'd20, 32'd0, 4'h0, 1, 11'd2000);
    check("init_no_rvalid", 32'(a_rvalid_v[0]), 32'd0);
    repeat (480) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (1023) @(negedge clk);
    check("ready_early", 32'(ready_v[0]), 32'd0);
    @(negedge clk);
    check("ready_exact", 32'(ready_v[0]), 32'd1);
    check("busy_done",   32'(busy_v[0]),  32'd0);

    drive(0, 0, 0, 0, 0, 1, 11'd0);
    check("b_rd0", b_rdata_v[0], 32'h0);
    drive(0, 0, 0, 0, 0, 1, 11'd5);
    check("b_rd5", b_rdata_v[0], 32'h5);
    check("b_rv5", 32'(b_rvalid_v[0]), 32'd1);
    drive(0, 0, 0, 0, 0, 1, 11'd1023);
    check("b_rd1023", b_rdata_v[0], 32'h3FF);
    drive(0, 0, 0, 0, 0, 1, 11'd20);
    check("init_write_dropped", b_rdata_v[0], 32'h14);

    drive(1, 1, 11'd7, 32'hDEADBEEF, 4'b1111, 0, 0);
    drive(1, 1, 11'd7, 32'h0000AA00, 4'b0010, 0, 0);
    drive(1, 0, 11'd7, 32'd0, 4'h0, 0, 0);
    check("be_merge", a_rdata_v[0], 32'hDEADAAEF);
    check("be_merge_z", a_rdata_v[1], 32'hDEADAAEF);
    check("a_rv_pulse", 32'(a_rvalid_v[0]), 32'd1);
    @(negedge clk);
    check("a_rv_drop", 32'(a_rvalid_v[0]), 32'd0);

    drive(1, 1, 11'd3, 32'h00000003, 4'b1111, 0, 0);
    drive(1, 1, 11'd3, 32'h12345678, 4'b0011, 1, 11'd3);
    check("fwd_on",  b_rdata_v[0], 32'h00005678);
    check("fwd_off", b_rdata_v[1], 32'h00000003);
    drive(1, 0, 11'd3, 32'd0, 4'h0, 1, 11'd3);
    check("ab_same", a_rdata_v[0], b_rdata_v[0] == 32'h00005678 ? a_rdata_v[0] ^ 32'd0 : 32'h00005678);
    check("a_after_fwd", a_rdata_v[1], 32'h00005678);

    drive(1, 1, 11'd2000, 32'h55555555, 4'hF, 0, 0);
    check("oor_err", 32'(err_v[0]), 32'd1);
    @(negedge clk);
    check("oor_err_drop", 32'(err_v[0]), 32'd0);
    drive(1, 0, 11'd2000, 32'd0, 4'h0, 1, 11'd976);
    check("oor_rd", a_rdata_v[0], 32'h0);
    check("oor_rv", 32'(a_rvalid_v[0]), 32'd1);
    check("no_alias", b_rdata_v[0], 32'h3D0);
    drive(0, 0, 0, 0, 0, 1, 11'd50);
    check("oor_b_small", b_rdata_v[1], 32'h0);
    check("oor_err_small", 32'(err_v[1]), 32'd1);
    check("in_rng_big", b_rdata_v[0], 32'h32);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      a_req   = ($urandom_range(0, 9) < 7);
      a_we    = $urandom_range(0, 1) != 0;
      a_be    = 4'($urandom_range(0, 15));
      a_wdata = $urandom;
      a_addr  = ($urandom_range(0, 7) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(0, 15));
      b_req   = ($urandom_range(0, 9) < 7);
      b_addr  = ($urandom_range(0, 7) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(0, 15));
    end
    @(negedge clk);
    a_req = 1'b0; a_we = 1'b0; b_req = 1'b0;

    drive(1, 1, 11'd9, 32'hFFFFFFFF, 4'hF, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_ready;
    drive(1, 0, 11'd9, 32'd0, 4'h0, 0, 0);
    check("reinit_zero", a_rdata_v[1], 32'h0);
    check("reinit_ident", a_rdata_v[0], 32'h9);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
